// File: rtl/serial_term_rx.sv
// rtl/serial_term_rx.sv - 8N1 UART receiver with show-ahead byte FIFO.
// Optional two-flop input synchroniser: define SERIAL_TERM_RX_SYNC_EN.
module serial_term_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] count,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;

  logic rx_s;

`ifdef SERIAL_TERM_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_in};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic            stop_sample, pop, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rd_data = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];

  // A pop in the stop-sample cycle frees a slot, so a full FIFO still accepts the byte.
  assign stop_sample = (state == STOP) && (cnt == BIT_LAST);
  assign pop  = rd_en && !empty;
  assign push = stop_sample && rx_s && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!push) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_term_rx.sv
// tb/tb_serial_term_rx.sv - randomized self-checking bench for serial_term_rx.
module tb_serial_term_rx;
  localparam int CPB   = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef SERIAL_TERM_RX_SYNC_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif
  localparam int STOP_TICK = CPB / 2 + 9 * CPB + SX;
  localparam int LAT       = STOP_TICK + 1;

  logic          clk = 1'b0;
  logic          reset, rx_in, rd_en;
  logic [7:0]    rd_data;
  logic          empty, full, frame_err, overrun;
  logic [AW:0]   count;

  int errors = 0;
  int checks = 0;
  logic [7:0] mq[$];
  int fe_seen, ov_seen, fall_at;

  serial_term_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full 10-bit frame starting in the current cycle (t0 = this cycle).
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int rd_at);
    logic was_empty;
    int   exp_ov;
    fe_seen = 0; ov_seen = 0; fall_at = -1;
    was_empty = empty;
    for (int i = 0; i < 10 * CPB; i++) begin
      int b;
      b = i / CPB;
      if (b == 0)      rx_in = 1'b0;
      else if (b == 9) rx_in = stop_v;
      else             rx_in = d[b-1];
      rd_en = (i == rd_at);
      if (i == rd_at && mq.size() > 0) begin
        checks++;
        if (rd_data !== mq[0]) begin
          errors++;
          $display("FAIL head_at_pop: got %0h expected %0h", rd_data, mq[0]);
        end
      end
      tick();
      rd_en = 1'b0;
      if (frame_err) fe_seen++;
      if (overrun)   ov_seen++;
      if (was_empty && !empty && fall_at < 0) fall_at = i + 1;
    end
    if (rd_at >= 0 && mq.size() > 0) void'(mq.pop_front());
    exp_ov = 0;
    if (stop_v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else exp_ov = 1;
    end
    checks++;
    if (fe_seen != (stop_v ? 0 : 1)) begin
      errors++;
      $display("FAIL frame_err_pulses: got %0d expected %0d", fe_seen, stop_v ? 0 : 1);
    end
    checks++;
    if (ov_seen != exp_ov) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d expected %0d", ov_seen, exp_ov);
    end
    checks++;
    if (count !== mq.size()) begin
      errors++;
      $display("FAIL count_after_frame: got %0d expected %0d", count, mq.size());
    end
    if (was_empty && stop_v) begin
      checks++;
      if (fall_at != LAT) begin
        errors++;
        $display("FAIL empty_latency: got %0d expected %0d", fall_at, LAT);
      end
    end
  endtask

  task automatic read_one();
    checks++;
    if (empty !== 1'b0 || rd_data !== mq[0]) begin
      errors++;
      $display("FAIL read_head: got %0h empty=%0b expected %0h", rd_data, empty, mq[0]);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(mq.pop_front());
    checks++;
    if (count !== mq.size() || empty !== (mq.size() == 0)) begin
      errors++;
      $display("FAIL read_count: got %0d empty=%0b expected %0d", count, empty, mq.size());
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 0 || frame_err !== 1'b0 ||
        overrun !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL %s: got e=%0b f=%0b c=%0d fe=%0b ov=%0b d=%0h expected 1 0 0 0 0 00",
               name, empty, full, count, frame_err, overrun, rd_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_in = 1'b1; rd_en = 1'b0;
    repeat (3) tick();
    check_reset_values("reset_state");
    reset = 1'b0;
    repeat (4) tick();
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1);
    checks++;
    if (rd_data !== 8'hA5 || count !== 1) begin
      errors++;
      $display("FAIL single_byte: got %0h count %0d expected a5 count 1", rd_data, count);
    end
    read_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 0) begin
      errors++;
      $display("FAIL pop_when_empty: got empty=%0b count=%0d expected 1 0", empty, count);
    end
  endtask

  task automatic test_glitch();
    int fe_cnt;
    fe_cnt = 0;
    rx_in = 1'b0;
    repeat (5) begin tick(); if (frame_err) fe_cnt++; end
    rx_in = 1'b1;
    repeat (4) begin tick(); if (frame_err) fe_cnt++; end
    checks++;
    if (fe_cnt != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL glitch: got fe=%0d empty=%0b expected 0 1", fe_cnt, empty);
    end
    send_frame(8'h5A, 1'b1, -1);
    read_one();
  endtask

  task automatic test_frame_err();
    int fe_cnt;
    fe_cnt = 0;
    send_frame(8'h3C, 1'b0, -1);
    repeat (200) begin tick(); if (frame_err) fe_cnt++; end
    checks++;
    if (fe_cnt != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL break_hold: got extra fe=%0d empty=%0b expected 0 1", fe_cnt, empty);
    end
    rx_in = 1'b1;
    repeat (5) tick();
    send_frame(8'h55, 1'b1, -1);
    read_one();
  endtask

  task automatic test_overrun_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 5; k++) begin
        send_frame(8'(k), 1'b1, -1);
        if (k >= 4) begin
          checks++;
          if (full !== 1'b1) begin
            errors++;
            $display("FAIL full_flag: got %0b expected 1 (rep %0d byte %0d)", full, r, k);
          end
        end
      end
      repeat (4) read_one();
    end
  endtask

  task automatic test_simultaneous();
    repeat (4) send_frame(8'($urandom_range(0, 255)), 1'b1, -1);
    send_frame(8'h77, 1'b1, STOP_TICK);
    checks++;
    if (count !== 4) begin
      errors++;
      $display("FAIL simul_count: got %0d expected 4", count);
    end
    repeat (3) read_one();
    checks++;
    if (rd_data !== 8'h77) begin
      errors++;
      $display("FAIL simul_last: got %0h expected 77", rd_data);
    end
    read_one();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic stop_v;
      stop_v = ($urandom_range(0, 7) != 0);
      send_frame(8'($urandom_range(0, 255)), stop_v, -1);
      rx_in = 1'b1;
      repeat ($urandom_range(stop_v ? 0 : 2, 12)) tick();
      while (mq.size() > 0 && $urandom_range(0, 2) != 0) read_one();
    end
    while (mq.size() > 0) read_one();
  endtask

  task automatic test_reset_midframe();
    send_frame(8'($urandom_range(0, 255)), 1'b1, -1);
    rx_in = 1'b0;
    repeat (CPB) tick();
    rx_in = 1'b1;
    repeat (4 * CPB + CPB / 2) tick();
    reset = 1'b1;
    tick();
    check_reset_values("reset_midframe");
    tick();
    reset = 1'b0;
    mq.delete();
    repeat (5 * CPB) tick();
    check_reset_values("lost_partial_frame");
    send_frame(8'h42, 1'b1, -1);
    read_one();
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun_wrap();
    test_simultaneous();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_term_rx.md
# serial_term_rx

UART receiver for the terminal end of the Altair SIO serial link: it deserialises the 8N1 stream driven by the machine's `tx` output into bytes. It buffers the bytes in a small show-ahead FIFO for a downstream consumer, such as an on-screen text terminal or the HPS bridge. It runs in the `CLK_50M` domain next to `altair` and is the receiving counterpart of the SIO transmitter.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); must be ≥ 4.
- `FIFO_AW`, 4: FIFO address width; depth is 2^FIFO_AW.

Ports:
- `clk`, input, 1: system clock. One clock only.
- `reset`, input, 1: synchronous, active-high reset.
- `rx_in`, input, 1: serial line; idles high; may be asynchronous.
- `rd_en`, input, 1: pop the head byte; ignored while `empty`.
- `rd_data`, output, 8: head byte (show-ahead); valid while `!empty`.
- `empty`, output, 1: FIFO holds no bytes.
- `full`, output, 1: FIFO holds 2^FIFO_AW bytes.
- `count`, output, FIFO_AW+1: current occupancy.
- `frame_err`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `rx_s` is the line as seen internally: `rx_in` after the optional synchroniser (see Configuration).
- The receive FSM has five states, `IDLE`, `START`, `DATA`, `STOP` and `WAIT_HI`, with a bit counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
- `IDLE`: when `rx_s`=0, clear the counter and go to `START`. Call this cycle t0.
- `START`: at t0+H, where H = CLKS_PER_BIT/2 (floor), sample `rx_s`.
  - 0: go to `DATA` and clear the counter and bit index.
  - 1: treat as a glitch and return to `IDLE`. Nothing is reported.
- `DATA`: sample every CLKS_PER_BIT cycles, at t0+H+k·CLKS_PER_BIT for k=1..8.
  - Shift each sample into the shift register LSB-first; bit 0 is received first.
  - After the 8th sample, go to `STOP`.
- `STOP`: sample at t0+H+9·CLKS_PER_BIT.
  - 1, FIFO not full: push the byte and go to `IDLE`.
  - 1, FIFO full and `rd_en`=0: drop the byte, pulse `overrun`, go to `IDLE`.
  - 0: discard the byte, pulse `frame_err`, go to `WAIT_HI`.
- `WAIT_HI`: stay until `rx_s`=1, then go to `IDLE`. A break condition therefore yields exactly one `frame_err`.
- Returning to `IDLE` at mid-stop-bit allows back-to-back frames with no gap.

FIFO:
- Circular buffer with read and write pointers of width FIFO_AW+1 (a wrap bit is used for full/empty).
- `full` = (MSBs differ) && (low bits equal); `empty` = (pointers equal).
- Push and pop in the same cycle:
  - Both apply; `count` is unchanged.
  - This holds even when full: the push is accepted because the pop frees the slot in the same cycle.
- `rd_en` while `empty`: no pointer change and no error.
- Pointer wrap-around at 2^FIFO_AW is seamless.

Reset (any cycle, including mid-frame):
- FSM returns to `IDLE` and pointers are cleared.
- `empty`=1, `full`=0, `count`=0, `frame_err`=0, `overrun`=0, `rd_data`=8'h00.
- Synchroniser flops reset to 1.
- A frame partially received when reset is applied is lost. Reception resumes on the next falling edge seen after reset is released.

## Timing
- Push occurs on the stop-sample cycle. In the next cycle `empty` falls, `count` increments, and `rd_data` shows the byte if the FIFO was empty.
- Latency from the `rx_s` falling edge (t0) to `!empty` is H + 9·CLKS_PER_BIT + 1 cycles. With the synchroniser enabled, add 2 cycles when measured from `rx_in`.
- `rd_en` is registered: `rd_data` advances and `count` decrements the cycle after `rd_en` is sampled high.
- `frame_err` and `overrun` are asserted in the cycle after the stop sample, for exactly one cycle.
- Tolerated baud mismatch: ±4% (the mid-bit sample must fall within the bit over 10 bits).

## Configuration
- `SERIAL_TERM_RX_SYNC_EN` defined: `rx_in` passes through two flops (reset value 1) before the FSM. This is required whenever `rx_in` comes from a pin or another clock domain.
- Not defined: `rx_s` = `rx_in` directly, for same-clock links and faster simulation. All latencies shrink by 2 cycles; FSM behaviour is otherwise identical.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `FIFO_AW`=2, with the synchroniser disabled unless stated.
- Single byte: send 0xA5 in 8N1 → `empty` falls exactly 153 cycles after t0, `rd_data`=0xA5, `count`=1; one `rd_en` → `empty`=1, `count`=0.
- Glitch: a 5-cycle low pulse on an idle line → no push, no `frame_err`, FSM back in `IDLE` by cycle t0+9.
- Framing error: send 0x3C with the stop bit low, then hold low for 200 cycles → one `frame_err` pulse, FIFO still empty; next valid 0x55 is received correctly.
- Overrun and wrap: send 5 bytes 0x01..0x05 with no reads → `full` after 4, `overrun` pulses once on the 5th, reads return 0x01..0x04. Repeat 3 times to exercise pointer wrap.
- Simultaneous events: with the FIFO full, assert `rd_en` on the stop-sample cycle of an incoming 0x77 → no `overrun`, `count` stays 4, 0x77 read out last.
- Reset mid-frame and synchroniser: assert `reset` during bit 4 of 0xFF → all outputs take their reset values; with `SERIAL_TERM_RX_SYNC_EN` defined, the next 0x42 arrives 155 cycles after the `rx_in` edge.
